// File: rtl/spike_bus_arbiter.sv
// -----------------------------------------------------------------------------
// spike_bus_arbiter
//
// Round-robin arbiter for the shared broadcast spike bus that feeds the synapse
// array. Each spike source offers one event (valid, polarity, address) through
// a valid/ready handshake. At most one source is granted per clock. The granted
// event is registered onto the bus one cycle later. A saturating counter tracks
// how many "on" events have been issued. The pause input blocks new grants
// while the synapse configuration chain is being shifted.
//
// Ports
//   clk            system clock
//   reset_n        asynchronous reset, active-low
//   src_valid      per-source event pending            [NUM_SRC]
//   src_on_off     per-source event polarity (1 = on)  [NUM_SRC]
//   src_address    per-source address, source i at [i*ADDR_W +: ADDR_W]
//   src_ready      one-hot grant (combinational)       [NUM_SRC]
//   pause          1 = no grants this cycle
//   spike_valid    bus event valid, one-cycle pulse per event
//   spike_on_off   bus event polarity
//   spike_address  bus event address                   [ADDR_W]
//   spike_count    saturating count of issued on events [CNT_W]
//   count_clr      synchronous clear of spike_count (wins over an increment)
// -----------------------------------------------------------------------------
module spike_bus_arbiter #(
    parameter int NUM_SRC = 4,
    parameter int ADDR_W  = 8,
    parameter int CNT_W   = 16
) (
    input  logic                      clk,
    input  logic                      reset_n,
    input  logic [NUM_SRC-1:0]        src_valid,
    input  logic [NUM_SRC-1:0]        src_on_off,
    input  logic [NUM_SRC*ADDR_W-1:0] src_address,
    output logic [NUM_SRC-1:0]        src_ready,
    input  logic                      pause,
    output logic                      spike_valid,
    output logic                      spike_on_off,
    output logic [ADDR_W-1:0]         spike_address,
    output logic [CNT_W-1:0]          spike_count,
    input  logic                      count_clr
);

    localparam int PTR_W = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1;

    logic [PTR_W-1:0]   rr_ptr;
    logic [PTR_W-1:0]   rr_ptr_nxt;
    logic [NUM_SRC-1:0] grant;
    logic               grant_any;
    logic [PTR_W-1:0]   grant_idx;
    logic               sel_on_off;
    logic [ADDR_W-1:0]  sel_address;

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] value);
        return (&value) ? value : value + CNT_W'(1);
    endfunction

    // The rotated search is split into two linear priority passes: first the
    // sources at or above rr_ptr, then the sources below it. This keeps every
    // select index constant and gives the same order as a modulo walk.
    always_comb begin
        grant       = '0;
        grant_any   = 1'b0;
        grant_idx   = '0;
        sel_on_off  = 1'b0;
        sel_address = '0;
        if (reset_n && !pause) begin
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!grant_any && src_valid[i] && (i >= int'(rr_ptr))) begin
                    grant[i]    = 1'b1;
                    grant_any   = 1'b1;
                    grant_idx   = PTR_W'(i);
                    sel_on_off  = src_on_off[i];
                    sel_address = src_address[i*ADDR_W +: ADDR_W];
                end
            end
            for (int i = 0; i < NUM_SRC; i++) begin
                if (!grant_any && src_valid[i] && (i < int'(rr_ptr))) begin
                    grant[i]    = 1'b1;
                    grant_any   = 1'b1;
                    grant_idx   = PTR_W'(i);
                    sel_on_off  = src_on_off[i];
                    sel_address = src_address[i*ADDR_W +: ADDR_W];
                end
            end
        end
    end

    assign src_ready = grant;

    // Pointer moves to the source after the winner, so the winner has lowest
    // priority next time. Explicit wrap keeps non-power-of-two counts legal.
    always_comb begin
        rr_ptr_nxt = rr_ptr;
        if (grant_any) begin
            rr_ptr_nxt = (grant_idx == PTR_W'(NUM_SRC - 1)) ? '0 : grant_idx + PTR_W'(1);
        end
    end

    // Bus output stage: one cycle after the grant.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rr_ptr        <= '0;
            spike_valid   <= 1'b0;
            spike_on_off  <= 1'b0;
            spike_address <= '0;
            spike_count   <= '0;
        end else begin
            rr_ptr      <= rr_ptr_nxt;
            spike_valid <= grant_any;
            if (grant_any) begin
                spike_on_off  <= sel_on_off;
                spike_address <= sel_address;
            end
            if (count_clr) begin
                spike_count <= '0;
            end else if (grant_any && sel_on_off) begin
                spike_count <= sat_inc(spike_count);
            end
        end
    end

endmodule

// File: tb/tb_spike_bus_arbiter.sv
module tb_spike_bus_arbiter;

    localparam int N  = 4;
    localparam int AW = 8;
    localparam int CW = 16;
    localparam int SW = 4;   // narrow counter instance for the saturation case

    logic              clk = 1'b0;
    logic              reset_n;
    logic [N-1:0]      src_valid;
    logic [N-1:0]      src_on_off;
    logic [N*AW-1:0]   src_address;
    logic [N-1:0]      src_ready;
    logic              pause;
    logic              spike_valid;
    logic              spike_on_off;
    logic [AW-1:0]     spike_address;
    logic [CW-1:0]     spike_count;
    logic              count_clr;

    logic [N-1:0]      s_ready;
    logic              s_valid;
    logic              s_on_off;
    logic [AW-1:0]     s_address;
    logic [SW-1:0]     s_count;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    spike_bus_arbiter #(.NUM_SRC(N), .ADDR_W(AW), .CNT_W(CW)) u_dut (
        .clk(clk), .reset_n(reset_n), .src_valid(src_valid), .src_on_off(src_on_off),
        .src_address(src_address), .src_ready(src_ready), .pause(pause),
        .spike_valid(spike_valid), .spike_on_off(spike_on_off),
        .spike_address(spike_address), .spike_count(spike_count), .count_clr(count_clr)
    );

    spike_bus_arbiter #(.NUM_SRC(N), .ADDR_W(AW), .CNT_W(SW)) u_sat (
        .clk(clk), .reset_n(reset_n), .src_valid(src_valid), .src_on_off(src_on_off),
        .src_address(src_address), .src_ready(s_ready), .pause(pause),
        .spike_valid(s_valid), .spike_on_off(s_on_off),
        .spike_address(s_address), .spike_count(s_count), .count_clr(count_clr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // Model state: where the next search starts, what the bus should show,
    // and the two counter values.
    int          m_next;
    logic        m_bv;
    logic        m_bo;
    logic [7:0]  m_ba;
    int          m_cnt;
    int          m_small;
    int          m_g;

    function automatic int pick(input int start, input logic [N-1:0] v);
        for (int k = 0; k < N; k++) begin
            if (v[(start + k) % N]) return (start + k) % N;
        end
        return -1;
    endfunction

    always_comb m_g = (pause || !reset_n) ? -1 : pick(m_next, src_valid);

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            m_next  <= 0;
            m_bv    <= 1'b0;
            m_bo    <= 1'b0;
            m_ba    <= 8'h00;
            m_cnt   <= 0;
            m_small <= 0;
        end else begin
            if (m_g >= 0) begin
                m_bv   <= 1'b1;
                m_bo   <= src_on_off[m_g];
                m_ba   <= src_address[m_g*AW +: AW];
                m_next <= (m_g + 1) % N;
            end else begin
                m_bv <= 1'b0;
            end
            if (count_clr) begin
                m_cnt   <= 0;
                m_small <= 0;
            end else if (m_g >= 0 && src_on_off[m_g]) begin
                if (m_cnt < (1 << CW) - 1) m_cnt <= m_cnt + 1;
                if (m_small < (1 << SW) - 1) m_small <= m_small + 1;
            end
        end
    end

    // Compare process: every cycle, away from the active edge.
    always @(negedge clk) begin
        logic [N-1:0] er;
        er = '0;
        if (m_g >= 0) er[m_g] = 1'b1;
        check("m_ready", src_ready, er);
        check("m_ready_s", s_ready, er);
        check("m_valid", spike_valid, m_bv);
        check("m_on_off", spike_on_off, m_bo);
        check("m_address", spike_address, m_ba);
        check("m_count", spike_count, m_cnt);
        check("m_count_s", s_count, m_small);
    end

    // ---------------- directed stimulus ----------------
    logic [7:0] fair_exp [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};
    logic [4:0] onoff_pat = 5'b10101;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset_n     = 1'b0;
        src_valid   = 4'b1111;
        src_on_off  = 4'b1111;
        src_address = {8'h13, 8'h12, 8'h11, 8'h10};
        pause       = 1'b0;
        count_clr   = 1'b0;

        // Reset / idle
        @(negedge clk);
        check("rst_ready", src_ready, 4'b0000);
        check("rst_valid", spike_valid, 1'b0);
        check("rst_count", spike_count, 16'h0000);
        step();
        reset_n = 1'b1;                              // cycle 0
        @(negedge clk);
        check("first_grant", src_ready, 4'b0001);

        // Fairness: bus shows grants of cycles 0..4
        for (int k = 0; k < 5; k++) begin
            step();                                  // cycles 1..5
            @(negedge clk);
            check("fair_valid", spike_valid, 1'b1);
            check("fair_addr", spike_address, fair_exp[k]);
        end

        // Wrap/skip: bring rr_ptr to 3, then only sources 0 and 2 request
        step(); src_valid = 4'b0100;                 // cycle 6
        @(negedge clk); check("wrap_pre", src_ready, 4'b0100);
        step(); src_valid = 4'b0101;                 // cycle 7
        @(negedge clk); check("wrap_g0", src_ready, 4'b0001);
        step();                                      // cycle 8
        @(negedge clk); check("wrap_g2", src_ready, 4'b0100);
        check("wrap_bus0", spike_address, 8'h10);
        step();                                      // cycle 9
        @(negedge clk); check("wrap_g0b", src_ready, 4'b0001);
        check("wrap_bus2", spike_address, 8'h12);

        // Pause
        step(); src_valid = 4'b1111;                 // cycle 10
        @(negedge clk); check("pre_pause", src_ready, 4'b0010);
        step(); pause = 1'b1;                        // cycle 11
        @(negedge clk); check("pause_rdy1", src_ready, 4'b0000);
        check("pause_inflight", spike_valid, 1'b1);
        check("pause_inflight_addr", spike_address, 8'h11);
        step();                                      // cycle 12
        @(negedge clk); check("pause_rdy2", src_ready, 4'b0000);
        check("pause_idle", spike_valid, 1'b0);
        step();                                      // cycle 13
        @(negedge clk); check("pause_rdy3", src_ready, 4'b0000);
        step(); pause = 1'b0;                        // cycle 14
        @(negedge clk); check("resume", src_ready, 4'b0100);

        // Counter: 3 on + 2 off events from source 0
        step(); src_valid = 4'b0000; count_clr = 1'b1;
        step(); count_clr = 1'b0;
        for (int k = 0; k < 5; k++) begin
            src_valid     = 4'b0001;
            src_on_off[0] = onoff_pat[k];
            step();
        end
        src_valid = 4'b0001; src_on_off[0] = 1'b1; count_clr = 1'b1;
        @(negedge clk); check("count_3", spike_count, 16'd3);
        step(); count_clr = 1'b0;
        @(negedge clk); check("clr_wins", spike_count, 16'd0);
        check("clr_event_issued", spike_valid, 1'b1);
        repeat (20) step();
        src_valid = 4'b0000;
        @(negedge clk);
        check("count_20", spike_count, 16'd20);
        check("count_sat", s_count, 4'hF);

        // Async reset mid-stream
        src_valid = 4'b1111;
        step(); step();
        #1 reset_n = 1'b0;
        #1;
        check("async_valid", spike_valid, 1'b0);
        check("async_ready", src_ready, 4'b0000);
        check("async_count", spike_count, 16'd0);
        step(); reset_n = 1'b1;
        @(negedge clk); check("post_rst_grant", src_ready, 4'b0001);
        step(); step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
